// File: rtl/zero_detect_mult.sv
// rtl/zero_detect_mult.sv - registered WIDTHxWIDTH multiplier with operand zero detection
//
// Purpose:
//   One product per accepted input, one clock after acceptance. A zero on
//   either operand bypasses the multiplier array: the array operands are gated
//   to zero, the product is forced to zero and the op is flagged as skipped.
//
// Parameters:
//   WIDTH   operand width in bits; the product is 2*WIDTH bits
//   SIGNED  0 = unsigned operands, 1 = two's-complement operands and product
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   valid_in    input qualifier, a/b are sampled when high
//   a, b        operands (WIDTH bits)
//   result      registered product (2*WIDTH bits)
//   skipped     registered, 1 when the accepted op had a zero operand
//   valid_out   registered one-cycle pulse per accepted op
//   skip_count  saturating count of accepted zero ops     (ZDM_STATS_EN only)
//   op_count    saturating count of accepted ops          (ZDM_STATS_EN only)
//
// Build option:
//   ZDM_STATS_EN  when defined, adds the skip_count/op_count statistics ports.

module zero_detect_mult #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   result,
    output logic                 skipped,
    output logic                 valid_out
`ifdef ZDM_STATS_EN
    ,
    output logic [31:0]          skip_count,
    output logic [31:0]          op_count
`endif
);

    localparam int PW = 2 * WIDTH;

    logic              zero;
    logic              mul_en;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [PW-1:0]     ext_a;
    logic [PW-1:0]     ext_b;
    logic [PW-1:0]     product;

    logic [PW-1:0]     result_d,  result_q;
    logic              skipped_d, skipped_q;
    logic              valid_d,   valid_q;

    // Zero detect works on the raw operand bits.
    assign zero   = (a == '0) || (b == '0);
    // The array only sees live operands on a non-zero accepted op; otherwise
    // its inputs are held at zero so it does not toggle.
    assign mul_en = valid_in && !zero;
    assign op_a   = mul_en ? a : '0;
    assign op_b   = mul_en ? b : '0;

    // Operands are extended to the full product width. For two's complement
    // the sign-extended product taken modulo 2^PW is the exact signed result,
    // so one unsigned partial-product array serves both modes.
    always_comb begin
        ext_a = '0;
        ext_b = '0;
        if (SIGNED) begin
            ext_a = {{WIDTH{op_a[WIDTH-1]}}, op_a};
            ext_b = {{WIDTH{op_b[WIDTH-1]}}, op_b};
        end else begin
            ext_a = {{WIDTH{1'b0}}, op_a};
            ext_b = {{WIDTH{1'b0}}, op_b};
        end
    end

    // Shift-and-add partial-product array, truncated to PW bits.
    always_comb begin
        product = '0;
        for (int i = 0; i < PW; i++) begin
            if (ext_b[i]) begin
                product = product + (ext_a << i);
            end
        end
    end

    // Next state: result/skipped only move on an accepted op and hold
    // otherwise; valid_out follows valid_in with one cycle of latency.
    always_comb begin
        result_d  = result_q;
        skipped_d = skipped_q;
        valid_d   = valid_in;
        if (valid_in) begin
            result_d  = zero ? '0 : product;
            skipped_d = zero;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q  <= '0;
            skipped_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            result_q  <= result_d;
            skipped_q <= skipped_d;
            valid_q   <= valid_d;
        end
    end

    assign result    = result_q;
    assign skipped   = skipped_q;
    assign valid_out = valid_q;

`ifdef ZDM_STATS_EN
    logic [31:0] op_cnt_d,   op_cnt_q;
    logic [31:0] skip_cnt_d, skip_cnt_q;

    // Saturating counters, advanced on the same edge that registers the result.
    always_comb begin
        op_cnt_d   = op_cnt_q;
        skip_cnt_d = skip_cnt_q;
        if (valid_in) begin
            if (op_cnt_q != 32'hFFFF_FFFF) begin
                op_cnt_d = op_cnt_q + 32'd1;
            end
            if (zero && (skip_cnt_q != 32'hFFFF_FFFF)) begin
                skip_cnt_d = skip_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_cnt_q   <= '0;
            skip_cnt_q <= '0;
        end else begin
            op_cnt_q   <= op_cnt_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

    assign op_count   = op_cnt_q;
    assign skip_count = skip_cnt_q;
`endif

endmodule

// File: tb/tb_zero_detect_mult.sv
// tb/tb_zero_detect_mult.sv - directed self-checking bench for zero_detect_mult

module tb_zero_detect_mult;

    logic        clk = 1'b0;
    logic        rst;

    logic        u_vin;
    logic [7:0]  u_a, u_b;
    logic [15:0] u_res;
    logic        u_skip, u_vout;

    logic        s_vin;
    logic [7:0]  s_a, s_b;
    logic [15:0] s_res;
    logic        s_skip, s_vout;

`ifdef ZDM_STATS_EN
    logic [31:0] u_skip_cnt, u_op_cnt;
    logic [31:0] s_skip_cnt, s_op_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    zero_detect_mult #(.WIDTH(8), .SIGNED(1'b0)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (u_vin),
        .a          (u_a),
        .b          (u_b),
        .result     (u_res),
        .skipped    (u_skip),
        .valid_out  (u_vout)
`ifdef ZDM_STATS_EN
        ,
        .skip_count (u_skip_cnt),
        .op_count   (u_op_cnt)
`endif
    );

    zero_detect_mult #(.WIDTH(8), .SIGNED(1'b1)) s_dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (s_vin),
        .a          (s_a),
        .b          (s_b),
        .result     (s_res),
        .skipped    (s_skip),
        .valid_out  (s_vout)
`ifdef ZDM_STATS_EN
        ,
        .skip_count (s_skip_cnt),
        .op_count   (s_op_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic u_op(input logic v, input logic [7:0] av, input logic [7:0] bv);
        u_vin = v;
        u_a   = av;
        u_b   = bv;
        tick();
    endtask

    task automatic s_op(input logic v, input logic [7:0] av, input logic [7:0] bv);
        s_vin = v;
        s_a   = av;
        s_b   = bv;
        tick();
    endtask

    task automatic u_expect(input string tag, input logic [15:0] r, input logic sk, input logic vo);
        chk({tag, ".result"},  {16'd0, u_res},  {16'd0, r});
        chk({tag, ".skipped"}, {31'd0, u_skip}, {31'd0, sk});
        chk({tag, ".valid"},   {31'd0, u_vout}, {31'd0, vo});
    endtask

    task automatic s_expect(input string tag, input logic [15:0] r, input logic sk, input logic vo);
        chk({tag, ".result"},  {16'd0, s_res},  {16'd0, r});
        chk({tag, ".skipped"}, {31'd0, s_skip}, {31'd0, sk});
        chk({tag, ".valid"},   {31'd0, s_vout}, {31'd0, vo});
    endtask

    initial begin
        rst   = 1'b1;
        u_vin = 1'b1; u_a = 8'd9; u_b = 8'd9;
        s_vin = 1'b0; s_a = 8'd0; s_b = 8'd0;

        // Reset held two cycles, with valid_in high to show it is ignored.
        tick();
        tick();
        u_expect("reset", 16'd0, 1'b0, 1'b0);
        s_expect("reset_s", 16'd0, 1'b0, 1'b0);

        rst = 1'b0;
        u_op(1'b1, 8'd5, 8'd3);
        u_expect("5x3", 16'd15, 1'b0, 1'b1);
        u_op(1'b0, 8'd77, 8'd0);
        u_expect("5x3_hold", 16'd15, 1'b0, 1'b0);

        // Zero operands.
        u_op(1'b1, 8'd0, 8'd7);
        u_expect("0x7", 16'd0, 1'b1, 1'b1);
        u_op(1'b1, 8'd9, 8'd0);
        u_expect("9x0", 16'd0, 1'b1, 1'b1);
        u_op(1'b1, 8'd0, 8'd0);
        u_expect("0x0", 16'd0, 1'b1, 1'b1);
        u_op(1'b0, 8'd4, 8'd4);
        u_expect("zero_hold", 16'd0, 1'b1, 1'b0);

        // Width boundary and ordinary products.
        u_op(1'b1, 8'd255, 8'd255);
        u_expect("255x255", 16'd65025, 1'b0, 1'b1);
        u_op(1'b1, 8'd1, 8'd200);
        u_expect("1x200", 16'd200, 1'b0, 1'b1);
        u_op(1'b1, 8'd12, 8'd10);
        u_expect("12x10", 16'd120, 1'b0, 1'b1);
        u_op(1'b1, 8'd128, 8'd2);
        u_expect("128x2", 16'd256, 1'b0, 1'b1);

        // Back-to-back stream.
        u_op(1'b1, 8'd3, 8'd4);
        u_expect("b2b0", 16'd12, 1'b0, 1'b1);
        u_op(1'b1, 8'd0, 8'd5);
        u_expect("b2b1", 16'd0, 1'b1, 1'b1);
        u_op(1'b1, 8'd6, 8'd0);
        u_expect("b2b2", 16'd0, 1'b1, 1'b1);
        u_op(1'b1, 8'd2, 8'd2);
        u_expect("b2b3", 16'd4, 1'b0, 1'b1);
        u_op(1'b0, 8'd0, 8'd0);
        u_expect("b2b_end", 16'd4, 1'b0, 1'b0);

        // Reset in the same cycle as an op discards it.
        rst = 1'b1;
        u_op(1'b1, 8'd7, 8'd7);
        u_expect("mid_rst", 16'd0, 1'b0, 1'b0);
        rst = 1'b0;
        u_op(1'b1, 8'd2, 8'd3);
        u_expect("post_rst", 16'd6, 1'b0, 1'b1);
        u_op(1'b0, 8'd0, 8'd0);
`ifdef ZDM_STATS_EN
        chk("u_op_count",   u_op_cnt,   32'd1);
        chk("u_skip_count", u_skip_cnt, 32'd0);
`endif

        // Signed instance; its counters were cleared by the mid-stream reset.
        s_op(1'b1, 8'hFF, 8'hFF);
        s_expect("s_m1xm1", 16'h0001, 1'b0, 1'b1);
        s_op(1'b1, 8'h80, 8'h01);
        s_expect("s_m128x1", 16'hFF80, 1'b0, 1'b1);
        s_op(1'b1, 8'h00, 8'h80);
        s_expect("s_0xm128", 16'h0000, 1'b1, 1'b1);
        s_op(1'b0, 8'h00, 8'h00);
        s_expect("s_idle", 16'h0000, 1'b1, 1'b0);
`ifdef ZDM_STATS_EN
        chk("s_op_count",   s_op_cnt,   32'd3);
        chk("s_skip_count", s_skip_cnt, 32'd1);
`endif
        s_op(1'b1, 8'h80, 8'h80);
        s_expect("s_m128xm128", 16'h4000, 1'b0, 1'b1);
        s_op(1'b1, 8'h7F, 8'h80);
        s_expect("s_127xm128", 16'hC080, 1'b0, 1'b1);
        s_op(1'b1, 8'hFD, 8'h05);
        s_expect("s_m3x5", 16'hFFF1, 1'b0, 1'b1);
        s_op(1'b0, 8'h00, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/zero_detect_mult.md
# zero_detect_mult

Registered WIDTH×WIDTH multiplier with operand zero detection for the datapath MAC/PE arrays. A zero on either operand bypasses the multiplier array, forces a zero product and flags the operation as skipped. This lets upstream sparsity logic count and exploit zero operands. One result is produced per accepted input, one clock after acceptance.

## Interface
- WIDTH, 8, operand width in bits; result is 2*WIDTH bits.
- SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands and result.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- valid_in  input  1  input qualifier; a and b are sampled when high.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- result  output  2*WIDTH  registered product.
- skipped  output  1  registered; 1 when the accepted op had a == 0 or b == 0.
- valid_out  output  1  registered; one-cycle pulse per accepted op.
- skip_count  output  32  skipped-op counter (only with ZDM_STATS_EN).
- op_count  output  32  accepted-op counter (only with ZDM_STATS_EN).

## Operation
- Zero detect: zero = (a == 0) || (b == 0), evaluated on raw operand bits.
- Zero op: result <= 0, skipped <= 1. Multiplier operands are gated to zero so the array does not toggle.
- Non-zero op: result <= a*b over the full 2*WIDTH width, with no truncation or overflow (unsigned 255×255 = 65025). skipped <= 0.
- SIGNED=1: operands are two's complement and the product is the exact signed 2*WIDTH result, e.g. -1×-1 = 1.
- Multiplier is combinational (partial-product array or synthesized `*`), followed by one output register stage.
- No back-pressure: every valid_in cycle is accepted; back-to-back valid_in gives back-to-back valid_out.
- While valid_in is low: valid_out <= 0; result and skipped hold their last values.

## Timing
- Latency is 1 cycle. Inputs sampled at rising edge N appear on result/skipped/valid_out after edge N and stay stable until edge N+1.
- valid_out is high for exactly one cycle per accepted op.
- Reset (rst high at an edge): result = 0, skipped = 0, valid_out = 0, counters = 0.
- Reset overrides everything: valid_in is ignored while rst is high, and an op sampled in the same cycle as rst is discarded.
- Reset mid-stream: the first valid_out after release belongs to the first op sampled with rst low.
- No X propagation: outputs are defined from the first reset onward regardless of a/b values when valid_in is low.

## Configuration
- ZDM_STATS_EN defined:
  - skip_count and op_count ports exist.
  - op_count increments on each accepted op; skip_count increments on each accepted zero op.
  - Both counters saturate at 2^32-1 and clear on rst.
  - Counters update on the same edge as the result.
- ZDM_STATS_EN undefined: counter ports and logic are absent; all other behaviour is identical.

## Test plan
- Reset: hold rst 2 cycles -> result=0, skipped=0, valid_out=0. Release, then apply 5×3 -> one cycle later result=15, skipped=0, valid_out=1; next cycle valid_out=0 and result still 15.
- Zero operands: 0×7, 9×0, 0×0 -> result=0, skipped=1, valid_out=1 each time.
- Width boundary: 255×255 -> 65025, skipped=0. Also 1×200 -> 200 and 12×10 -> 120.
- Back-to-back: valid_in held high for 4 cycles with 3×4, 0×5, 6×0, 2×2 -> valid_out high for 4 consecutive cycles, results 12, 0, 0, 4 and skipped 0, 1, 1, 0.
- Reset mid-stream: assert rst in the same cycle as an op -> no valid_out for that op, and outputs are at reset values.
- SIGNED=1 with ZDM_STATS_EN: 0xFF×0xFF -> 1; 0x80×0x01 -> 0xFF80; 0×0x80 -> skipped. op_count=3 and skip_count=1 afterwards.
